// File: rtl/watch_pkg.sv
// Shared definitions for the watch button front end:
// button indices, channel FSM states and default timing.
package watch_pkg;

    localparam int BTN_RESET      = 0;
    localparam int BTN_START_STOP = 1;
    localparam int BTN_MODE       = 2;
    localparam int BTN_EDIT_SHIFT = 3;
    localparam int BTN_INC        = 4;

    localparam int DEF_NUM_BTN         = BTN_INC + 1;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_LONG_CYCLES     = 15_000_000;
    localparam int DEF_REPEAT_CYCLES   = 25_000_000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } btn_state_e;

    // Width of a counter whose largest value is n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: two-flop synchroniser, debounce counter and
// press/short/long/repeat/release event FSM with registered pulses.
module btn_channel
    import watch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic release_pulse
);

    localparam int DB_W   = cnt_w(DEBOUNCE_CYCLES);
    localparam int HOLD_W = cnt_w(LONG_CYCLES);
    localparam int REP_W  = cnt_w(REPEAT_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_level;
    logic [DB_W-1:0]   r_db_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [REP_W-1:0]  r_rep_cnt;
    btn_state_e        r_state;
    btn_state_e        w_state_nxt;

    logic w_hold_last;
    logic w_rep_last;
    logic w_press_nxt;
    logic w_short_nxt;
    logic w_long_nxt;
    logic w_repeat_nxt;
    logic w_release_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Any sample that agrees with the accepted level restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level  <= 1'b0;
            r_db_cnt <= '0;
        end else if (r_sync2 == r_level) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
            r_level  <= ~r_level;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
        end
    end

    assign w_hold_last = (r_hold_cnt == HOLD_LAST);
    assign w_rep_last  = (r_rep_cnt == REP_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Release is tested first so it beats a coincident long or repeat.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (r_level) w_state_nxt = ST_PRESSED;
            end
            ST_PRESSED: begin
                if (!r_level)        w_state_nxt = ST_IDLE;
                else if (w_hold_last) w_state_nxt = ST_HELD;
            end
            ST_HELD: begin
                if (!r_level) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_press_nxt   = 1'b0;
        w_short_nxt   = 1'b0;
        w_long_nxt    = 1'b0;
        w_repeat_nxt  = 1'b0;
        w_release_nxt = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_press_nxt = r_level;
            end
            ST_PRESSED: begin
                w_short_nxt   = ~r_level;
                w_release_nxt = ~r_level;
                w_long_nxt    = r_level & w_hold_last;
            end
            ST_HELD: begin
                w_release_nxt = ~r_level;
                w_repeat_nxt  = r_level & w_rep_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold_cnt <= '0;
            r_rep_cnt  <= '0;
        end else begin
            unique case (r_state)
                ST_PRESSED: begin
                    r_hold_cnt <= w_hold_last ? '0 : r_hold_cnt + HOLD_W'(1);
                    r_rep_cnt  <= '0;
                end
                ST_HELD: begin
                    r_hold_cnt <= '0;
                    r_rep_cnt  <= w_rep_last ? '0 : r_rep_cnt + REP_W'(1);
                end
                default: begin
                    r_hold_cnt <= '0;
                    r_rep_cnt  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_pulse   <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= w_press_nxt;
            short_pulse   <= w_short_nxt;
            long_pulse    <= w_long_nxt;
            repeat_pulse  <= w_repeat_nxt;
            release_pulse <= w_release_nxt;
        end
    end

    assign btn_level = r_level;

endmodule

// File: rtl/button_conditioner.sv
// Watch push-button front end: one independent conditioning
// channel per button, outputs gathered into per-event vectors.
module button_conditioner
    import watch_pkg::*;
#(
    parameter int NUM_BTN         = DEF_NUM_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] short_pulse,
    output logic [NUM_BTN-1:0] long_pulse,
    output logic [NUM_BTN-1:0] repeat_pulse,
    output logic [NUM_BTN-1:0] release_pulse
);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .btn_raw       (btn_raw[g]),
            .btn_level     (btn_level[g]),
            .press_pulse   (press_pulse[g]),
            .short_pulse   (short_pulse[g]),
            .long_pulse    (long_pulse[g]),
            .repeat_pulse  (repeat_pulse[g]),
            .release_pulse (release_pulse[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short timing:
// debounce 4, long 20, repeat 8.
module tb_button_conditioner;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] press_pulse;
    logic [N-1:0] short_pulse;
    logic [N-1:0] long_pulse;
    logic [N-1:0] repeat_pulse;
    logic [N-1:0] release_pulse;

    int nerr = 0;
    int nchk = 0;

    button_conditioner #(
        .NUM_BTN         (N),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20),
        .REPEAT_CYCLES   (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .short_pulse   (short_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int hi;
        int press_at;
        int short_at;
        int long_at;
        int rep_n;
        int rel_at;
        int lvl_n;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int all_out();
        return int'({btn_level, press_pulse, short_pulse,
                     long_pulse, repeat_pulse, release_pulse});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one channel high for v.hi samples, then low, and log events.
    task automatic run_vec(input int idx, input vec_t v);
        int press_at = -1, short_at = -1, long_at = -1, rel_at = -1;
        int np = 0, ns = 0, nl = 0, nr = 0, nrel = 0, nlvl = 0, other = 0;
        logic [N-1:0] om;
        om = ~(N'(1) << v.ch);
        btn_raw = N'(1) << v.ch;
        for (int k = 1; k <= v.hi + 15; k++) begin
            tick();
            if (press_pulse[v.ch]) begin
                np++;
                if (press_at < 0) press_at = k;
            end
            if (short_pulse[v.ch]) begin
                ns++;
                if (short_at < 0) short_at = k;
            end
            if (long_pulse[v.ch]) begin
                nl++;
                if (long_at < 0) long_at = k;
            end
            if (release_pulse[v.ch]) begin
                nrel++;
                if (rel_at < 0) rel_at = k;
            end
            if (repeat_pulse[v.ch]) nr++;
            if (btn_level[v.ch]) nlvl++;
            if (((press_pulse | short_pulse | long_pulse | repeat_pulse
                  | release_pulse | btn_level) & om) != '0) other++;
            if (k == v.hi) btn_raw = '0;
        end
        check($sformatf("v%0d press_at", idx), press_at, v.press_at);
        check($sformatf("v%0d press_n", idx), np, v.press_at >= 0 ? 1 : 0);
        check($sformatf("v%0d short_at", idx), short_at, v.short_at);
        check($sformatf("v%0d short_n", idx), ns, v.short_at >= 0 ? 1 : 0);
        check($sformatf("v%0d long_at", idx), long_at, v.long_at);
        check($sformatf("v%0d long_n", idx), nl, v.long_at >= 0 ? 1 : 0);
        check($sformatf("v%0d repeat_n", idx), nr, v.rep_n);
        check($sformatf("v%0d release_at", idx), rel_at, v.rel_at);
        check($sformatf("v%0d release_n", idx), nrel, v.rel_at >= 0 ? 1 : 0);
        check($sformatf("v%0d level_n", idx), nlvl, v.lvl_n);
        check($sformatf("v%0d other_ch", idx), other, 0);
    endtask

    initial begin
        int at;
        int cnt;
        int nrep;

        //          ch  hi press short long rep  rel lvl
        vecs[0] = '{2,  3,  -1,  -1,  -1,  0,  -1,  0};
        vecs[1] = '{4, 10,   7,  17,  -1,  0,  17, 10};
        vecs[2] = '{4, 60,   7,  -1,  27,  4,  67, 60};
        vecs[3] = '{4, 20,   7,  27,  -1,  0,  27, 20};
        vecs[4] = '{0,  4,   7,  11,  -1,  0,  11,  4};
        vecs[5] = '{1, 21,   7,  -1,  27,  0,  28, 21};
        vecs[6] = '{3, 28,   7,  -1,  27,  0,  35, 28};
        vecs[7] = '{3, 29,   7,  -1,  27,  1,  36, 29};

        // All buttons held through reset.
        reset   = 1'b0;
        btn_raw = '1;
        repeat (3) tick();
        check("reset_outputs", all_out(), 0);
        reset = 1'b1;
        at  = -1;
        cnt = 0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (press_pulse != '0) begin
                cnt++;
                if (at < 0 && press_pulse == '1) at = k;
            end
        end
        check("reset_press_at", at, 7);
        check("reset_press_n", cnt, 1);
        btn_raw = '0;
        cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (release_pulse == '1 && short_pulse == '1) cnt++;
        end
        check("reset_release_all", cnt, 1);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Reset dropped while a channel sits in HELD.
        btn_raw = 5'b10000;
        cnt = 0;
        for (int k = 1; k <= 35; k++) begin
            tick();
            if (repeat_pulse[4]) cnt++;
        end
        check("held_repeat_before_rst", cnt, 1);
        #1 reset = 1'b0;
        #1 check("async_reset_outputs", all_out(), 0);
        repeat (2) tick();
        reset = 1'b1;
        at   = -1;
        nrep = 0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (repeat_pulse != '0 || long_pulse != '0) nrep++;
            if (press_pulse[4] && at < 0) at = k;
        end
        check("post_rst_stale_events", nrep, 0);
        check("post_rst_press_at", at, 7);
        btn_raw = '0;
        repeat (20) tick();
        check("final_idle", all_out(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
